// File: rtl/program_loader.sv
// program_loader
//   Writes a program image into the CPU's unified 8-bit memory while holding
//   the CPU in reset, then releases it once the image checksum matches.
//
//   Stream format: <len> <data x len> <checksum>
//     len      : data byte count, 0 encodes 256
//     checksum : 8-bit sum of all data bytes
//
//   Ports
//     clk, reset_n      : clock (rising edge), async active-low reset
//     start             : single-cycle pulse, begins a load from IDLE/DONE/ERROR
//     in_valid/in_ready : byte stream handshake, in_data carries the byte
//     mem_addr/din/we   : memory write port, one we pulse per data byte,
//                         issued the cycle after the byte is accepted
//     cpu_reset         : holds the CPU in reset until a load succeeds
//     busy              : loader is consuming a stream (LEN/DATA/CHECK)
//     done / error      : load outcome; timeout qualifies error
//     byte_count        : data bytes written in the current load
//
//   Optional build macro PROGRAM_LOADER_TIMEOUT_EN: aborts a stalled load
//   into ERROR (timeout=1) after TIMEOUT_CYCLES cycles without a transfer.
//   Without it, timeout is tied low and the loader waits indefinitely.
module program_loader #(
  parameter int              ADDR_W         = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic [8:0]        byte_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t     state;
  logic [8:0] remaining;   // data bytes still expected, 256 fits in 9 bits
  logic [7:0] csum;
  logic       xfer;

  assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
  assign busy     = in_ready;
  assign xfer     = in_valid && in_ready;

`ifdef PROGRAM_LOADER_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_expire;

  // Fires on the cycle whose idle tick brings the count to TIMEOUT_CYCLES.
  assign idle_expire = busy && !xfer &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cpu_reset  <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
      remaining  <= '0;
      csum       <= '0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
      timeout    <= 1'b0;
      idle_cnt   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;

`ifdef PROGRAM_LOADER_TIMEOUT_EN
      // Held at zero outside LEN/DATA/CHECK, so entry to LEN starts clean.
      if (xfer || !busy) idle_cnt <= '0;
      else               idle_cnt <= idle_cnt + IDLE_W'(1);
`endif

      case (state)
        S_IDLE: begin
          cpu_reset  <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
          byte_count <= '0;
          csum       <= '0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
          timeout    <= 1'b0;
`endif
          if (start) state <= S_LEN;
        end

        S_LEN: if (xfer) begin
          remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          state     <= S_DATA;
        end

        S_DATA: if (xfer) begin
          mem_we     <= 1'b1;
          // byte_count still holds this byte's index; address wraps naturally.
          mem_addr   <= BASE_ADDR + ADDR_W'(byte_count);
          mem_din    <= in_data;
          csum       <= csum + in_data;
          byte_count <= byte_count + 9'd1;
          remaining  <= remaining - 9'd1;
          if (remaining == 9'd1) state <= S_CHECK;
        end

        S_CHECK: if (xfer) begin
          if (in_data == csum) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end

        S_DONE, S_ERROR: if (start) begin
          // Re-arm: CPU goes back into reset on the same edge as LEN entry.
          state      <= S_LEN;
          cpu_reset  <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
          byte_count <= '0;
          csum       <= '0;
`ifdef PROGRAM_LOADER_TIMEOUT_EN
          timeout    <= 1'b0;
`endif
        end

        default: state <= S_IDLE;
      endcase

`ifdef PROGRAM_LOADER_TIMEOUT_EN
      // Overrides any same-cycle case decision; no transfer happened anyway.
      if (idle_expire) begin
        state   <= S_ERROR;
        error   <= 1'b1;
        timeout <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader. Two instances share one stream:
// u0 with BASE_ADDR 0x00 and u1 with BASE_ADDR 0x10, so every load also
// exercises address offset and wrap. Data-byte accepts push expected
// writes (addr, data, cycle) into per-instance queues; monitors pop and
// compare on every mem_we.
module tb_program_loader;

  logic       clk, reset_n, start, in_valid;
  logic [7:0] in_data;

  logic       rdy0, we0, crst0, busy0, done0, err0, to0;
  logic [7:0] addr0, din0;
  logic [8:0] cnt0;
  logic       rdy1, we1, crst1, busy1, done1, err1, to1;
  logic [7:0] addr1, din1;
  logic [8:0] cnt1;

  program_loader #(.ADDR_W(8), .BASE_ADDR(8'h00), .TIMEOUT_CYCLES(8)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy0), .mem_addr(addr0), .mem_din(din0),
    .mem_we(we0), .cpu_reset(crst0), .busy(busy0), .done(done0),
    .error(err0), .timeout(to0), .byte_count(cnt0));

  program_loader #(.ADDR_W(8), .BASE_ADDR(8'h10), .TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy1), .mem_addr(addr1), .mem_din(din1),
    .mem_we(we1), .cpu_reset(crst1), .busy(busy1), .done(done1),
    .error(err1), .timeout(to1), .byte_count(cnt1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t       q0[$], q1[$];
  int         checks = 0, errors = 0;
  int         cyc = 0;
  int         we_cnt0 = 0, we_cnt1 = 0;
  logic [7:0] last_a0 = '0, last_a1 = '0;
  logic [8:0] idx = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitors: one pop per write, checking address, data and 1-cycle latency.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (we0 === 1'b1) begin
      we_cnt0++;
      last_a0 = addr0;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_write actual=%0h:%0h expected=none", addr0, din0);
      end else begin
        e = q0.pop_front();
        chk("u0_wr_addr", addr0, e.a);
        chk("u0_wr_data", din0, e.d);
        chk("u0_wr_latency", cyc, e.c);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (we1 === 1'b1) begin
      we_cnt1++;
      last_a1 = addr1;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_write actual=%0h:%0h expected=none", addr1, din1);
      end else begin
        e = q1.pop_front();
        chk("u1_wr_addr", addr1, e.a);
        chk("u1_wr_data", din1, e.d);
        chk("u1_wr_latency", cyc, e.c);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] b, input bit dat);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = b;
    while (!(rdy0 && rdy1) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL send_ready_wait actual=not_ready expected=ready");
    end
    if (dat) begin
      e.d = b;
      e.c = cyc + 1;
      e.a = idx[7:0];
      q0.push_back(e);
      e.a = 8'(8'h10 + idx[7:0]);
      q1.push_back(e);
      idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = '0;
  endtask

  task automatic status(input string nm, input bit d, input bit er, input bit cr,
                        input logic [8:0] cnt, input bit bz, input bit to);
    chk({nm, "_u0_done"},  done0, d);   chk({nm, "_u1_done"},  done1, d);
    chk({nm, "_u0_error"}, err0, er);   chk({nm, "_u1_error"}, err1, er);
    chk({nm, "_u0_cpurst"}, crst0, cr); chk({nm, "_u1_cpurst"}, crst1, cr);
    chk({nm, "_u0_count"}, cnt0, cnt);  chk({nm, "_u1_count"}, cnt1, cnt);
    chk({nm, "_u0_busy"},  busy0, bz);  chk({nm, "_u1_busy"},  busy1, bz);
    chk({nm, "_u0_tmo"},   to0, to);    chk({nm, "_u1_tmo"},   to1, to);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);

    // Reset state
    status("rst", 0, 0, 1, 0, 0, 0);
    chk("rst_u0_we", we0, 0);     chk("rst_u1_we", we1, 0);
    chk("rst_u0_addr", addr0, 0); chk("rst_u1_addr", addr1, 0);
    chk("rst_u0_din", din0, 0);   chk("rst_u1_din", din1, 0);
    chk("rst_u0_rdy", rdy0, 0);
    reset_n = 1'b1;
    @(negedge clk);
    // IDLE ignores in_valid without start
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_rdy", rdy0, 0);
    in_valid = 1'b0;

    // T1: good 3-byte load, 0x61+0x22+0xE0 = 0x163 -> 0x63
    pulse_start();
    send(8'h03, 0); send(8'h61, 1); send(8'h22, 1); send(8'hE0, 1);
    send(8'h63, 0);
    status("t1", 1, 0, 0, 3, 0, 0);
    chk("t1_q0_empty", q0.size(), 0); chk("t1_q1_empty", q1.size(), 0);

    // T2: bad checksum
    pulse_start();
    status("t2_start", 0, 0, 1, 0, 1, 0);
    send(8'h03, 0); send(8'h61, 1); send(8'h22, 1); send(8'hE0, 1);
    send(8'h64, 0);
    status("t2", 0, 1, 1, 3, 0, 0);
    chk("t2_q0_empty", q0.size(), 0);

    // T3: length 0 = 256 bytes, sum 0..255 = 0x7F80 -> 0x80; u1 wraps to 0x0F
    pulse_start();
    status("t3_start", 0, 0, 1, 0, 1, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) send(8'(i), 1);
    send(8'h80, 0);
    status("t3", 1, 0, 0, 256, 0, 0);
    chk("t3_u0_last_addr", last_a0, 8'hFF);
    chk("t3_u1_last_addr", last_a1, 8'h0F);
    chk("t3_q1_empty", q1.size(), 0);

    // T4: gapped stream, start pulsed mid-DATA is ignored
    pulse_start();
    c0 = we_cnt0; c1 = we_cnt1;
    send(8'h02, 0);
    @(negedge clk);
    send(8'h05, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    status("t4_mid", 0, 0, 1, 1, 1, 0);
    send(8'hFA, 1);
    @(negedge clk);
    send(8'hFF, 0);
    status("t4", 1, 0, 0, 2, 0, 0);
    chk("t4_u0_we_pulses", we_cnt0 - c0, 2);
    chk("t4_u1_we_pulses", we_cnt1 - c1, 2);

    // T5: reset mid-load, then a fresh full load
    pulse_start();
    send(8'h03, 0); send(8'h11, 1);
    #2 reset_n = 1'b0;
    #1;
    status("t5_rst", 0, 0, 1, 0, 0, 0);
    chk("t5_u0_we", we0, 0); chk("t5_u1_we", we1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_q0_empty", q0.size(), 0);
    pulse_start();
    send(8'h03, 0); send(8'h61, 1); send(8'h22, 1); send(8'hE0, 1);
    send(8'h63, 0);
    status("t5", 1, 0, 0, 3, 0, 0);

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    // T6: stall after 1 of 2 bytes; 8th idle cycle aborts
    pulse_start();
    send(8'h02, 0); send(8'h01, 1);
    repeat (7) @(negedge clk);
    status("t6_pre", 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    status("t6", 0, 1, 1, 1, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Loads a program image into the CPU's unified 8-bit instruction/data memory while holding the CPU in reset, then releases it.
- It is the writer end of the same memory that the CPU fetch/decode/execute FSM reads.
- Accepts a length-prefixed, checksummed byte stream over a valid/ready handshake.
- Drives the memory write port, and asserts cpu_reset until a load completes with a valid checksum.

Parameters:
- ADDR_W, 8, memory address width; program counter and memory address width.
- BASE_ADDR, 8'h00, address of the first byte written; addresses wrap modulo 2^ADDR_W.
- TIMEOUT_CYCLES, 255, idle-cycle limit (used only with PROGRAM_LOADER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_W  memory write address.
- mem_din  output  8  memory write data.
- mem_we  output  1  memory write enable, one cycle per byte.
- cpu_reset  output  1  holds the CPU in reset while high.
- busy  output  1  high in LEN, DATA and CHECK.
- done  output  1  load succeeded.
- error  output  1  checksum mismatch or timeout.
- timeout  output  1  error cause was a timeout.
- byte_count  output  9  data bytes written in the current load.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE.
  - cpu_reset=1.
  - mem_we=0, mem_addr=0, mem_din=0.
  - in_ready=0, busy=0, done=0, error=0, timeout=0, byte_count=0.
  - Checksum accumulator=0.
- Handshake: a byte transfers on a rising edge where in_valid&&in_ready.
  - in_ready is a combinational decode of state: high only in LEN, DATA and CHECK.
  - in_data is ignored when no transfer occurs.
- States:
  - IDLE: start -> LEN. Clear byte_count and checksum; cpu_reset=1, done=0, error=0, timeout=0.
  - LEN: on transfer, remaining = in_data, with 0 meaning 256 (9-bit counter) -> DATA.
  - DATA: on each transfer:
    - Next cycle: mem_we=1, mem_addr=(BASE_ADDR+byte_count) mod 2^ADDR_W, mem_din=byte. Write latency is exactly 1 cycle.
    - checksum += byte (mod 256), byte_count++, remaining--.
    - When remaining reaches 0 -> CHECK.
  - CHECK: on transfer, compare in_data with the checksum.
    - Equal -> DONE.
    - Otherwise -> ERROR.
  - DONE: done=1, cpu_reset=0. start -> LEN, re-asserting cpu_reset the same cycle and clearing done, byte_count and checksum.
  - ERROR: error=1, cpu_reset=1. start -> LEN, clearing error, timeout, byte_count and checksum.
- mem_we pulses exactly once per accepted data byte; it is never asserted for length or checksum bytes.
- start is ignored in LEN, DATA and CHECK.
- start coincident with in_valid in IDLE/DONE/ERROR: no byte is consumed that cycle (in_ready=0).
- Back-to-back transfers sustain 1 byte/cycle; gaps in in_valid are allowed without limit unless the timeout feature is on.
- mem_addr and mem_din hold their last values when mem_we=0.
- Reset mid-load: returns to IDLE immediately; cpu_reset=1. Partially written memory is not restored.

Optional Feature:
- PROGRAM_LOADER_TIMEOUT_EN defined:
  - An idle counter clears on every transfer and on entry to LEN.
  - It increments each cycle in LEN/DATA/CHECK without a transfer.
  - When the count reaches TIMEOUT_CYCLES -> ERROR with timeout=1.
- Undefined: no counter; timeout tied 0; the loader waits forever.

Test Plan:
- BASE_ADDR=0x00; start, then stream 0x03,0x61,0x22,0xE0,0x63.
  -> Writes (0x00,0x61), (0x01,0x22), (0x02,0xE0), each 1 cycle after its accept.
  -> Then done=1, cpu_reset=0, byte_count=3.
- Same stream with checksum 0x64.
  -> Three writes occur; error=1, done=0, cpu_reset stays 1.
- BASE_ADDR=0x10; length byte 0x00, 256 bytes of value i, checksum 0x80.
  -> Last write at addr 0x0F; byte_count=256; done=1.
- Length 2, in_valid toggled every other cycle, start pulsed mid-DATA.
  -> start ignored; exactly 2 mem_we pulses; done after correct checksum.
- reset_n dropped after 1 of 3 data bytes.
  -> Immediately state IDLE, cpu_reset=1, mem_we=0, byte_count=0.
  -> A new start with a full stream succeeds.
- With PROGRAM_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=8: send length 2 and one byte, then hold in_valid low.
  -> After 8 idle cycles: error=1, timeout=1, cpu_reset=1.
